ysyx_23060077_riscv_axi_master: RTL
===================================

Name: ysyx_23060077_riscv_axi_master

Overview:
- Single-outstanding AXI-lite initiator; the master end of the data-memory / SRAM AXI port.
- Converts a simple valid/ready request/response bus from the CPU (IFU or LSU) into AR/R or AW/W/B channel transactions.
- Adds a watchdog that flags a hung slave.
- Sits between the core's memory stage and the AXI SRAM responder or arbiter.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width
- STRB_W, 4, write strobe width (DATA_W/8)
- RESP_W, 2, response width
- PORT_W, 3, AxPROT width
- PORT_VAL, 3'b000, constant driven on aw_port/ar_port
- TIMEOUT, 1024, max cycles waiting on any single handshake; 0 disables the watchdog

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- req_valid_i  in  1  CPU request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  DATA_W  write data
- req_wstrb_i  in  STRB_W  write byte enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  CPU consumes response
- rsp_rdata_o  out  DATA_W  read data (0 for writes)
- rsp_err_o  out  1  slave returned resp!=0
- timeout_o  out  1  sticky watchdog flag
- aw_valid_o / aw_ready_i / aw_port_o / aw_addr_o  out/in/out/out  1/1/PORT_W/ADDR_W  write address channel
- w_valid_o / w_ready_i / w_strb_o / w_data_o  out/in/out/out  1/1/STRB_W/DATA_W  write data channel
- b_valid_i / b_ready_o / b_resp_i  in/out/in  1/1/RESP_W  write response channel
- ar_valid_o / ar_ready_i / ar_port_o / ar_addr_o  out/in/out/out  1/1/PORT_W/ADDR_W  read address channel
- r_valid_i / r_ready_o / r_resp_i / r_data_i  in/out/in/in  1/1/RESP_W/DATA_W  read data channel

Behaviour:
- Reset (areset high at a rising edge): state IDLE; all valid/ready outputs 0; rsp_rdata_o 0, rsp_err_o 0, timeout_o 0; address/data registers 0. Reset mid-transaction aborts the transaction immediately; no response is produced.
- States: IDLE, RADDR, RDATA, WADDR_DATA, WRESP, RESP, HUNG.
- IDLE: req_ready_o=1 (combinational from state). On req_valid_i, latch addr/wdata/wstrb/we. Next state is RADDR (we=0) or WADDR_DATA (we=1). The AXI valid goes high on the following cycle, one cycle after acceptance.
- RADDR: ar_valid_o=1, ar_addr_o/ar_port_o stable. On ar_ready_i: ar_valid_o drops next cycle; go to RDATA.
- RDATA: r_ready_o=1, held continuously until r_valid_i. On r_valid_i: latch r_data_i into rsp_rdata_o; rsp_err_o=(r_resp_i!=0); go to RESP.
- WADDR_DATA: aw_valid_o and w_valid_o both asserted on entry. Each drops independently on its own handshake; internal aw_done/w_done flags record completion.
  - Handshakes may occur in the same cycle or in either order.
  - When both are done (including same-cycle completion), go to WRESP.
  - Valid/payload never change before their handshake.
- WRESP: b_ready_o=1 until b_valid_i. Then rsp_rdata_o=0, rsp_err_o=(b_resp_i!=0); go to RESP.
- RESP: rsp_valid_o=1 with data/err held stable until rsp_ready_i. On rsp_ready_i: rsp_valid_o drops next cycle; go to IDLE. req_ready_o is 0 in RESP (no overlap).
- Minimum latency: accept at T → valid T+1 → slave ready T+1 → R/B beat T+2 → rsp_valid T+3.
- Watchdog:
  - A 16-bit counter clears on every state change and increments each cycle in RADDR/RDATA/WADDR_DATA/WRESP.
  - When the counter reaches TIMEOUT (TIMEOUT≠0): deassert all AXI valid/ready, set timeout_o=1, go to HUNG.
  - HUNG: req_ready_o=0 and rsp_valid_o=0; the block stays there until reset.
- Any AXI inputs arriving in a state where they are not expected are ignored.

Test Plan:
- Read at 0x8000_0010, slave raises ar_ready 1 cycle after ar_valid and r_valid with data 0xDEADBEEF, resp 0 after 5 cycles → ar_valid high exactly until the handshake; r_ready held throughout the wait; rsp_valid with rdata 0xDEADBEEF, err 0.
- Write 0x8000_0020, data 0x12345678, strb 4'b0011: aw_ready in cycle 2, w_ready in cycle 4 → aw_valid drops after cycle 2, w_valid stays high until cycle 4; b_ready asserted afterwards; rsp_valid, err 0.
- Write where w_ready precedes aw_ready, then a second write where both arrive in the same cycle → both complete correctly with no duplicate handshake.
- Read completing with rsp_ready held low 4 cycles → rsp_valid/rdata stable 4 cycles; req_ready 0 throughout; next request is accepted only after IDLE is re-entered.
- Write with b_resp=2'b10 → rsp_err_o=1, rdata 0.
- TIMEOUT=8, slave never asserts ar_ready → after 8 cycles in RADDR: ar_valid 0, timeout_o 1, req_ready 0 forever. Then areset pulse → timeout_o 0 and req_ready 1.

Source files
------------

// File: rtl/ysyx_23060077_riscv_axi_master.sv
// ysyx_23060077_riscv_axi_master: single-outstanding AXI-lite initiator bridging a CPU valid/ready bus, with hang watchdog
// Ports: aclk/areset (sync, active-high); req_*/rsp_* CPU request/response side; aw/w/b/ar/r AXI-lite channels; timeout_o sticky hang flag
module ysyx_23060077_riscv_axi_master #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                STRB_W   = 4,
    parameter int                RESP_W   = 2,
    parameter int                PORT_W   = 3,
    parameter logic [PORT_W-1:0] PORT_VAL = '0,
    parameter int                TIMEOUT  = 1024
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              timeout_o,
    output logic              aw_valid_o,
    input  logic              aw_ready_i,
    output logic [PORT_W-1:0] aw_port_o,
    output logic [ADDR_W-1:0] aw_addr_o,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [STRB_W-1:0] w_strb_o,
    output logic [DATA_W-1:0] w_data_o,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [RESP_W-1:0] b_resp_i,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [PORT_W-1:0] ar_port_o,
    output logic [ADDR_W-1:0] ar_addr_o,
    input  logic              r_valid_i,
    output logic              r_ready_o,
    input  logic [RESP_W-1:0] r_resp_i,
    input  logic [DATA_W-1:0] r_data_i
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR_DATA, WRESP, RESP, HUNG} state_t;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              aw_done, w_done;
    logic [15:0]       wd_cnt;
    logic              aw_hs, w_hs, wr_done, busy, wd_hit;
    assign aw_hs   = aw_valid_o & aw_ready_i;
    assign w_hs    = w_valid_o & w_ready_i;
    // write phase ends once both channels have handshaken, counting a same-cycle completion
    assign wr_done = (aw_done | aw_hs) & (w_done | w_hs);
    assign busy    = state inside {RADDR, RDATA, WADDR_DATA, WRESP};
    // fires on the last permitted cycle so a waiting state lasts exactly TIMEOUT cycles; a handshake in that cycle still wins
    assign wd_hit  = (TIMEOUT != 0) && busy && (wd_cnt == 16'(TIMEOUT - 1));
    always_ff @(posedge aclk) state <= areset ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = req_valid_i ? (req_we_i ? WADDR_DATA : RADDR) : IDLE;
            RADDR:      state_nxt = ar_ready_i ? RDATA : wd_hit ? HUNG : RADDR;
            RDATA:      state_nxt = r_valid_i ? RESP : wd_hit ? HUNG : RDATA;
            WADDR_DATA: state_nxt = wr_done ? WRESP : wd_hit ? HUNG : WADDR_DATA;
            WRESP:      state_nxt = b_valid_i ? RESP : wd_hit ? HUNG : WRESP;
            RESP:       state_nxt = rsp_ready_i ? IDLE : RESP;
            default:    state_nxt = HUNG;
        endcase
    end
    always_comb begin
        req_ready_o = (state == IDLE) && !areset;
        ar_valid_o  = state == RADDR;
        r_ready_o   = state == RDATA;
        aw_valid_o  = (state == WADDR_DATA) && !aw_done;
        w_valid_o   = (state == WADDR_DATA) && !w_done;
        b_ready_o   = state == WRESP;
        rsp_valid_o = state == RESP;
        timeout_o   = state == HUNG;
        aw_addr_o   = addr;
        ar_addr_o   = addr;
        aw_port_o   = PORT_VAL;
        ar_port_o   = PORT_VAL;
        w_data_o    = wdata;
        w_strb_o    = wstrb;
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            addr        <= '0;
            wdata       <= '0;
            wstrb       <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            if (state == IDLE && req_valid_i) begin
                addr    <= req_addr_i;
                wdata   <= req_wdata_i;
                wstrb   <= req_wstrb_i;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (state == RDATA && r_valid_i) begin
                rsp_rdata_o <= r_data_i;
                rsp_err_o   <= |r_resp_i;
            end
            if (state == WRESP && b_valid_i) begin
                rsp_rdata_o <= '0;
                rsp_err_o   <= |b_resp_i;
            end
            wd_cnt <= (busy && state_nxt == state) ? wd_cnt + 16'd1 : '0;
        end
    end
endmodule
